// File: rtl/snowman_pkg.sv
// Shared colours, snowman geometry and motion state type for the snowman renderer.
package snowman_pkg;

    localparam logic [11:0] SKY    = 12'h48C;
    localparam logic [11:0] GROUND = 12'hCCD;
    localparam logic [11:0] SNOW   = 12'hFFF;
    localparam logic [11:0] EYE    = 12'h000;
    localparam logic [11:0] BLANK  = 12'h000;

    // First vertical-blanking line; the frame tick fires at its column 0.
    localparam logic [9:0] TICK_ROW = 10'd480;

    localparam int unsigned N_BALLS = 3;
    localparam int          BALL_DY [N_BALLS] = '{0, -62, -106};
    localparam int unsigned BALL_R  [N_BALLS] = '{40, 28, 18};
    localparam logic [21:0] BALL_R2 [N_BALLS] = '{22'(BALL_R[0] * BALL_R[0]),
                                                  22'(BALL_R[1] * BALL_R[1]),
                                                  22'(BALL_R[2] * BALL_R[2])};

    localparam int                 EYE_DY   = -110;
    localparam logic signed [10:0] EYE_DX   = 11'sd6;
    localparam logic signed [10:0] EYE_HALF = 11'sd1;

    typedef enum logic {MOVE_RIGHT, MOVE_LEFT} dir_t;

    function automatic logic [20:0] sq(input logic signed [10:0] a);
        logic signed [21:0] w;
        w = 22'(a);
        return 21'(w * w);
    endfunction

endpackage

// File: rtl/snowman_motion.sv
// Frame-tick detection and bouncing horizontal position of the snowman.
module snowman_motion
    import snowman_pkg::*;
#(
    parameter int unsigned X_INIT = 320,
    parameter int unsigned X_MIN  = 40,
    parameter int unsigned X_MAX  = 599,
    parameter int unsigned STEP   = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] h_cnt,
    input  logic [9:0] v_cnt,
    input  logic       move_en,
    output logic [9:0] pos_x
);

    dir_t dir;
    logic tick;

    assign tick = (h_cnt == '0) && (v_cnt == TICK_ROW);

    // Limits compared in 11 bits so the step can never wrap past either edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos_x <= 10'(X_INIT);
            dir   <= MOVE_RIGHT;
        end else if (tick && move_en) begin
            unique case (dir)
                MOVE_RIGHT: begin
                    if ({1'b0, pos_x} + 11'(STEP) >= 11'(X_MAX)) begin
                        pos_x <= 10'(X_MAX);
                        dir   <= MOVE_LEFT;
                    end else begin
                        pos_x <= pos_x + 10'(STEP);
                    end
                end
                MOVE_LEFT: begin
                    if ({1'b0, pos_x} <= 11'(X_MIN) + 11'(STEP)) begin
                        pos_x <= 10'(X_MIN);
                        dir   <= MOVE_RIGHT;
                    end else begin
                        pos_x <= pos_x - 10'(STEP);
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/snowman_renderer.sv
// Two-stage pixel pipeline drawing sky, ground and a sliding three-ball snowman
// with sync outputs delayed to stay aligned with the registered colour.
module snowman_renderer
    import snowman_pkg::*;
#(
    parameter int unsigned X_INIT   = 320,
    parameter int unsigned Y_BASE   = 400,
    parameter int unsigned X_MIN    = 40,
    parameter int unsigned X_MAX    = 599,
    parameter int unsigned STEP     = 2,
    parameter int unsigned GROUND_Y = 440
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] h_cnt,
    input  logic [9:0] v_cnt,
    input  logic       visible,
    input  logic       hsync_in,
    input  logic       vsync_in,
    input  logic       move_en,
    output logic [3:0] vga_r,
    output logic [3:0] vga_g,
    output logic [3:0] vga_b,
    output logic       hsync_o,
    output logic       vsync_o
);

    logic [9:0] pos_x;

    snowman_motion #(
        .X_INIT(X_INIT),
        .X_MIN (X_MIN),
        .X_MAX (X_MAX),
        .STEP  (STEP)
    ) u_motion (
        .clk    (clk),
        .rst_n  (rst_n),
        .h_cnt  (h_cnt),
        .v_cnt  (v_cnt),
        .move_en(move_en),
        .pos_x  (pos_x)
    );

    logic signed [10:0] dx_c, v_s, edy_c;
    logic signed [10:0] dy_c [N_BALLS];
    logic               eye_c;

    always_comb begin
        v_s   = signed'({1'b0, v_cnt});
        dx_c  = signed'({1'b0, pos_x}) - signed'({1'b0, h_cnt});
        for (int unsigned i = 0; i < N_BALLS; i++) begin
            dy_c[i] = 11'(int'(Y_BASE) + BALL_DY[i]) - v_s;
        end
        edy_c = 11'(int'(Y_BASE) + EYE_DY) - v_s;
        eye_c = (edy_c >= -EYE_HALF) && (edy_c <= EYE_HALF) &&
                (((dx_c >= EYE_DX - EYE_HALF) && (dx_c <= EYE_DX + EYE_HALF)) ||
                 ((dx_c >= -EYE_DX - EYE_HALF) && (dx_c <= -EYE_DX + EYE_HALF)));
    end

    logic signed [10:0] s1_dx;
    logic signed [10:0] s1_dy [N_BALLS];
    logic               s1_eye, s1_ground, s1_vis, s1_hs, s1_vs;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_dx <= '0;
            for (int unsigned i = 0; i < N_BALLS; i++) begin
                s1_dy[i] <= '0;
            end
            s1_eye    <= 1'b0;
            s1_ground <= 1'b0;
            s1_vis    <= 1'b0;
            s1_hs     <= 1'b1;
            s1_vs     <= 1'b1;
        end else begin
            s1_dx <= dx_c;
            for (int unsigned i = 0; i < N_BALLS; i++) begin
                s1_dy[i] <= dy_c[i];
            end
            s1_eye    <= eye_c;
            s1_ground <= v_cnt >= 10'(GROUND_Y);
            s1_vis    <= visible;
            s1_hs     <= hsync_in;
            s1_vs     <= vsync_in;
        end
    end

    logic [21:0] d2;
    logic        ball_c;
    logic [11:0] colour_c;

    always_comb begin
        d2     = '0;
        ball_c = 1'b0;
        for (int unsigned i = 0; i < N_BALLS; i++) begin
            d2 = 22'(sq(s1_dx)) + 22'(sq(s1_dy[i]));
            if (d2 <= BALL_R2[i]) begin
                ball_c = 1'b1;
            end
        end
        if (!s1_vis)        colour_c = BLANK;
        else if (s1_eye)    colour_c = EYE;
        else if (ball_c)    colour_c = SNOW;
        else if (s1_ground) colour_c = GROUND;
        else                colour_c = SKY;
    end

    logic [11:0] rgb;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rgb     <= '0;
            hsync_o <= 1'b1;
            vsync_o <= 1'b1;
        end else begin
            rgb     <= colour_c;
            hsync_o <= s1_hs;
            vsync_o <= s1_vs;
        end
    end

    assign vga_r = rgb[11:8];
    assign vga_g = rgb[7:4];
    assign vga_b = rgb[3:0];

endmodule

// File: tb/tb_snowman_renderer.sv
// Bench for snowman_renderer: geometric pixel model checked every cycle plus directed probes.
module tb_snowman_renderer;

    localparam int X_INIT = 320;
    localparam int Y_BASE = 400;
    localparam int X_MIN  = 40;
    localparam int X_MAX  = 599;
    localparam int STEP   = 2;
    localparam int GROUND = 440;

    logic       clk, rst_n;
    logic [9:0] h_cnt, v_cnt;
    logic       visible, hsync_in, vsync_in, move_en;
    logic [3:0] vga_r, vga_g, vga_b;
    logic       hsync_o, vsync_o;

    int n_cmp = 0;
    int n_err = 0;

    snowman_renderer #(
        .X_INIT  (X_INIT),
        .Y_BASE  (Y_BASE),
        .X_MIN   (X_MIN),
        .X_MAX   (X_MAX),
        .STEP    (STEP),
        .GROUND_Y(GROUND)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .h_cnt   (h_cnt),
        .v_cnt   (v_cnt),
        .visible (visible),
        .hsync_in(hsync_in),
        .vsync_in(vsync_in),
        .move_en (move_en),
        .vga_r   (vga_r),
        .vga_g   (vga_g),
        .vga_b   (vga_b),
        .hsync_o (hsync_o),
        .vsync_o (vsync_o)
    );

    initial begin
        clk = 1'b0;
        forever #20 clk = ~clk;
    end

    task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %03h expected %03h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int iabs(input int a);
        return (a < 0) ? -a : a;
    endfunction

    // What the screen shows at (h,v) with the snowman centred on column p.
    function automatic logic [11:0] pix(input int h, input int v, input int p, input bit vis);
        int cy [3];
        int r  [3];
        cy = '{Y_BASE, Y_BASE - 62, Y_BASE - 106};
        r  = '{40, 28, 18};
        if (!vis) return 12'h000;
        if ((iabs(h - (p - 6)) <= 1 || iabs(h - (p + 6)) <= 1) && iabs(v - (Y_BASE - 110)) <= 1)
            return 12'h000;
        for (int k = 0; k < 3; k++)
            if ((h - p) * (h - p) + (v - cy[k]) * (v - cy[k]) <= r[k] * r[k]) return 12'hFFF;
        if (v >= GROUND) return 12'hCCD;
        return 12'h48C;
    endfunction

    typedef struct packed {
        logic [11:0] rgb;
        logic        hs;
        logic        vs;
    } out_t;

    localparam out_t RST_OUT = '{rgb: 12'h000, hs: 1'b1, vs: 1'b1};

    int m_pos;
    bit m_right;

    initial begin
        out_t stored, prev;
        stored  = RST_OUT;
        prev    = RST_OUT;
        m_pos   = X_INIT;
        m_right = 1'b1;
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                m_pos   = X_INIT;
                m_right = 1'b1;
                stored  = RST_OUT;
                prev    = RST_OUT;
            end else begin
                prev       = stored;
                stored.rgb = pix(int'(h_cnt), int'(v_cnt), m_pos, visible);
                stored.hs  = hsync_in;
                stored.vs  = vsync_in;
                if (h_cnt == 0 && v_cnt == 480 && move_en) begin
                    if (m_right) begin
                        if (m_pos + STEP >= X_MAX) begin m_pos = X_MAX; m_right = 1'b0; end
                        else m_pos = m_pos + STEP;
                    end else begin
                        if (m_pos - STEP <= X_MIN) begin m_pos = X_MIN; m_right = 1'b1; end
                        else m_pos = m_pos - STEP;
                    end
                end
            end
            #1;
            check("model_rgb", {vga_r, vga_g, vga_b}, prev.rgb);
            check("model_hsync", 12'(hsync_o), 12'(prev.hs));
            check("model_vsync", 12'(vsync_o), 12'(prev.vs));
        end
    end

    task automatic probe(input int h, input int v, input logic [11:0] exp, input string name);
        @(negedge clk);
        h_cnt    = 10'(h);
        v_cnt    = 10'(v);
        visible  = (h < 640) && (v < 480);
        hsync_in = 1'($urandom);
        vsync_in = 1'($urandom);
        repeat (2) begin
            @(negedge clk);
            hsync_in = 1'($urandom);
            vsync_in = 1'($urandom);
        end
        check(name, {vga_r, vga_g, vga_b}, exp);
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            h_cnt = 10'd0; v_cnt = 10'd480; visible = 1'b0;
            @(negedge clk);
            h_cnt = 10'd1;
        end
    endtask

    task automatic drive_line(input int v);
        for (int h = 0; h < 800; h++) begin
            @(negedge clk);
            h_cnt    = 10'(h);
            v_cnt    = 10'(v);
            visible  = (h < 640) && (v < 480);
            hsync_in = !(h >= 656 && h < 752);
            vsync_in = !(v >= 490 && v < 492);
        end
    endtask

    initial begin
        int rows [17];
        rows = '{10, 288, 289, 290, 291, 292, 398, 399, 400, 401, 402, 439, 440, 441, 480, 490, 491};
        rst_n = 1'b1; h_cnt = '0; v_cnt = '0; visible = 1'b0;
        hsync_in = 1'b1; vsync_in = 1'b1; move_en = 1'b0;
        #5 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_rgb", {vga_r, vga_g, vga_b}, 12'h000);
        check("reset_hsync", 12'(hsync_o), 12'h001);
        check("reset_vsync", 12'(vsync_o), 12'h001);
        rst_n = 1'b1;

        probe(320, 400, 12'hFFF, "centre");
        probe(10, 10, 12'h48C, "sky");
        probe(10, 460, 12'hCCD, "ground");
        probe(700, 100, 12'h000, "blanking");
        probe(360, 400, 12'hFFF, "circle_edge_in");
        probe(361, 400, 12'h48C, "circle_edge_out");
        probe(314, 290, 12'h000, "eye_left");
        probe(326, 290, 12'h000, "eye_right");
        probe(320, 290, 12'hFFF, "between_eyes");
        probe(320, 440, 12'hFFF, "ball_over_ground");
        probe(320, 441, 12'hCCD, "below_ball");

        // Single-cycle hsync pulse must come out exactly two cycles later.
        @(negedge clk); hsync_in = 1'b1; vsync_in = 1'b1;
        @(negedge clk); hsync_in = 1'b0;
        @(negedge clk); hsync_in = 1'b1;
        check("hsync_delay_1", 12'(hsync_o), 12'h001);
        @(negedge clk);
        check("hsync_delay_2", 12'(hsync_o), 12'h000);
        @(negedge clk);
        check("hsync_delay_3", 12'(hsync_o), 12'h001);

        foreach (rows[i]) drive_line(rows[i]);
        probe(360, 400, 12'hFFF, "frozen_frame");

        move_en = 1'b1;
        tick(10);
        probe(380, 400, 12'hFFF, "pos340_edge_in");
        probe(381, 400, 12'h48C, "pos340_edge_out");
        probe(334, 290, 12'h000, "pos340_eye");
        move_en = 1'b0;
        tick(3);
        probe(380, 400, 12'hFFF, "hold340_edge_in");
        probe(381, 400, 12'h48C, "hold340_edge_out");

        move_en = 1'b1;
        tick(129);
        probe(638, 400, 12'hFFF, "pos598_in");
        probe(639, 400, 12'h48C, "pos598_out");
        tick(1);
        probe(639, 400, 12'hFFF, "clamp599");
        tick(1);
        probe(637, 400, 12'hFFF, "pos597_in");
        probe(638, 400, 12'h48C, "pos597_out");
        tick(278);
        probe(1, 400, 12'hFFF, "pos41_in");
        probe(0, 400, 12'h48C, "pos41_out");
        tick(1);
        probe(0, 400, 12'hFFF, "clamp40");
        tick(1);
        probe(2, 400, 12'hFFF, "pos42_in");
        probe(1, 400, 12'h48C, "pos42_out");

        // Asynchronous reset in the middle of a line.
        @(negedge clk);
        h_cnt = 10'd320; v_cnt = 10'd400; visible = 1'b1;
        @(negedge clk);
        #7 rst_n = 1'b0;
        #1;
        check("midreset_rgb", {vga_r, vga_g, vga_b}, 12'h000);
        check("midreset_hsync", 12'(hsync_o), 12'h001);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        probe(360, 400, 12'hFFF, "after_reset_in");
        probe(361, 400, 12'h48C, "after_reset_out");

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
